// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// default baud divisor and the processor-visible register addresses.
package mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // 50 MHz processor clock, 500 kbaud serial link to the AVR.
  localparam int DEFAULT_CLKS_PER_BIT = 100;

  localparam logic [7:0] UART_TX_DATA_ADDR   = 8'hF0;
  localparam logic [7:0] UART_TX_STATUS_ADDR = 8'hF1;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor-side MMIO bundle: store strobe/data and overflow clear going in,
// status flags coming back on the read path.
interface mmio_uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          tx_active;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  tx_active, fifo_full, fifo_count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output tx_active, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small first-word-fall-through FIFO; the head is always visible on dout so
// the transmitter can pop and load its shift register in the same cycle.
module mmio_uart_tx_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: processor stores are queued in a FIFO
// and sent to the AVR, pausing between frames while the AVR reports busy.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  mmio_uart_tx_if.slave    bus,
  input  logic             avr_rx_busy,
  output logic             tx
);

  localparam int         CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic [15:0]   baud_q, baud_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    busy_sync_q, busy_sync_d;
  logic          busy_s;
  logic          pop, drop, bit_done;
  logic          fifo_empty, fifo_full;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  mmio_uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.wr_en),
    .pop   (pop),
    .din   (bus.wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy_s   = busy_sync_q[1];
  assign bit_done = (baud_q == 16'd0);

  always_comb begin
    busy_sync_d = {busy_sync_q[0], avr_rx_busy};
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    baud_d      = baud_q;
    pop         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Busy only gates the start of a frame; a started frame always completes.
        if (!fifo_empty && !busy_s) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          bit_d   = 3'd0;
          baud_d  = BAUD_RELOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_d  = BAUD_RELOAD;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          baud_d  = BAUD_RELOAD;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered from the next state so the line changes with the state.
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase

    drop  = bus.wr_en && fifo_full && !pop;
    ovf_d = drop ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'd0;
      bit_q       <= 3'd0;
      baud_q      <= 16'd0;
      tx_q        <= 1'b1;
      ovf_q       <= 1'b0;
      busy_sync_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      baud_q      <= baud_d;
      tx_q        <= tx_d;
      ovf_q       <= ovf_d;
      busy_sync_q <= busy_sync_d;
    end
  end

  assign tx             = tx_q;
  assign bus.tx_active  = (state_q != ST_IDLE);
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = ovf_q;

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter sitting directly downstream of the multi-cycle processor's memory-mapped I/O port on the Mojo board. Processor stores of a byte are queued in a small FIFO and serialised 8N1 onto the FPGA-to-AVR serial line (`avr_rx`). Transmission pauses between frames while the AVR reports its receive buffer full. Status outputs are returned to the processor's memory-mapped read path.

## Interface
Parameters:
- `CLKS_PER_BIT`, 100 — clock cycles per serial bit (50 MHz / 500 kbaud); legal range 2..65535.
- `FIFO_DEPTH`, 4 — byte entries; power of two, 2..16.

Ports:
- `clk`  in  1  — processor clock domain (`clk_d`); single clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `wr_en`  in  1  — one-cycle pulse; processor store to the TX data address.
- `wr_data`  in  8  — byte to send; sampled when `wr_en`=1.
- `clr_ovf`  in  1  — one-cycle pulse; clears `overflow`.
- `avr_rx_busy`  in  1  — AVR RX buffer full; asynchronous to `clk`.
- `tx`  out  1  — serial output to `avr_rx`; idle high.
- `tx_active`  out  1  — a frame is on the line (state ≠ IDLE).
- `fifo_full`  out  1  — FIFO holds `FIFO_DEPTH` bytes.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  — bytes queued, excluding the frame in flight.
- `overflow`  out  1  — sticky; a write was dropped.

## Operation
- Reset values: `tx`=1, `tx_active`=0, `fifo_full`=0, `fifo_count`=0, `overflow`=0. FSM is in IDLE, FIFO is empty, and the busy synchroniser is cleared to 0.
- `avr_rx_busy` passes through a 2-flop synchroniser to form `busy_s`. Only `busy_s` is used.
- FIFO write rules:
  - A write is accepted when not full, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
  - If `clr_ovf` and a dropped write occur together, `overflow` stays set.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is not empty and `busy_s`=0, pop the head into the shift register, clear the bit counter, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift[0], LSB first. Shift every `CLKS_PER_BIT` cycles. After 8 bits, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- `busy_s` is checked only in IDLE. A frame already started always completes.
- The baud counter reloads on every state entry and every bit boundary. It never free-runs in IDLE.
- `fifo_count` is unsigned. Simultaneous push and pop leaves it unchanged.

## Timing
- `tx` is registered, so there is no combinational path from any input to `tx`.
- Write at edge N into an empty FIFO while idle and `busy_s`=0:
  - count=1 after edge N;
  - pop at edge N+1, with `tx` falling after edge N+1;
  - the frame lasts exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: IDLE lasts exactly 1 cycle between STOP end and the next START.
- Busy latency: `avr_rx_busy` rising at edge M blocks any frame start from edge M+2 onward. Release behaves the same way.
- Reset asserted mid-frame: `tx` goes to 1 immediately, asynchronously. FIFO contents are discarded and the partial frame is not resumed.

## Structure
- Shared package/defines: FSM state encoding (2 bits), the default `CLKS_PER_BIT`, and the TX data/status addresses used by the processor's memory map.
- One sub-module: `sync_fifo` (parameterised width/depth, push/pop/full/empty/count). It holds the byte queue; the UART FSM and baud counter live in `mmio_uart_tx`.

## Test plan
- Reset, then write 0xA5 with `CLKS_PER_BIT`=4 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; start falls 2 cycles after `wr_en`.
- Write 0x01, 0x02, 0x03 back-to-back → three frames separated by exactly one idle-high cycle; `fifo_count` peaks at 2.
- `FIFO_DEPTH`=4: hold `avr_rx_busy`=1 and write 6 bytes → the first 4 are kept, `fifo_full`=1, `overflow`=1. Pulse `clr_ovf` → `overflow`=0. Release busy → 4 frames sent in order.
- Assert `avr_rx_busy` mid-frame → the current frame completes; the next start is withheld until 2 cycles after busy deasserts.
- Write when full in the same cycle as an IDLE pop → byte accepted, `overflow` stays 0, count unchanged.
- Assert `rst` mid-DATA → `tx`=1 without waiting for a clock edge, `fifo_count`=0. After release, no residual frame is sent.
